// File: rtl/rlbp_readout_if.sv
// Code delivery handshake between the readout sequencer and its consumer.
interface rlbp_readout_if #(
  parameter int unsigned N_PIX = 12
);
  logic [N_PIX-1:0] code_o;
  logic             code_valid_o;
  logic             code_ready_i;

  modport master (output code_o, code_valid_o, input code_ready_i);
  modport slave  (input code_o, code_valid_o, output code_ready_i);
endinterface

// File: rtl/rlbp_readout_seq.sv
// Ring-LBP photodiode readout sequencer: per-channel S/H reset, sample and compare
// phases with programmable lengths, comparator capture into an N_PIX-bit LBP code.
module rlbp_readout_seq #(
  parameter int unsigned N_PIX = 12,
  parameter int unsigned CNT_W = 8,
  parameter int unsigned CH_W  = 5
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             cont_i,
  input  logic [N_PIX-1:0] ch_mask_i,
  input  logic [CNT_W-1:0] t_rst_i,
  input  logic [CNT_W-1:0] t_sh_i,
  input  logic [CNT_W-1:0] t_cmp_i,
  input  logic             cmp_i,
  output logic             sw1_o,
  output logic             sw2_o,
  output logic             sh_rst_o,
  output logic             sh_o,
  output logic             sh_cmp_o,
  output logic [N_PIX-1:0] pd_a_o,
  output logic [N_PIX-1:0] pd_b_o,
  output logic             busy_o,
  rlbp_readout_if.master   code_if
);

  typedef enum logic [2:0] {
    S_IDLE, S_RST, S_SAMPLE, S_COMPARE, S_LATCH, S_NEXT, S_DONE
  } state_e;

  localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_PIX - 1);

  function automatic logic [CNT_W-1:0] len_m1(input logic [CNT_W-1:0] t);
    return (t == '0) ? '0 : t - CNT_W'(1);
  endfunction

  state_e             state_q, state_d;
  logic [CH_W-1:0]    ch_q, ch_d, ch_inc;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N_PIX-1:0]   acc_q, acc_d, code_q, code_d;
  logic [N_PIX-1:0]   mask_q, mask_d;
  logic               cont_q, cont_d;
  logic [CNT_W-1:0]   trst_q, trst_d, tsh_q, tsh_d, tcmp_q, tcmp_d;
  logic               cmp_s1_q, cmp_s2_q;
  logic [N_PIX-1:0]   cur_oh, nxt_oh, d_oh;
  logic               sw1_q, sw2_q, sh_rst_q, sh_q, sh_cmp_q, busy_q, valid_q;
  logic               sw1_d, sw2_d, sh_rst_d, sh_d, sh_cmp_d, busy_d, valid_d;
  logic [N_PIX-1:0]   pd_a_q, pd_b_q, pd_a_d, pd_b_d;

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    code_d  = code_q;
    mask_d  = mask_q;
    cont_d  = cont_q;
    trst_d  = trst_q;
    tsh_d   = tsh_q;
    tcmp_d  = tcmp_q;
    ch_inc  = ch_q + CH_W'(1);
    cur_oh  = N_PIX'(1) << ch_q;
    nxt_oh  = N_PIX'(1) << ch_inc;

    unique case (state_q)
      S_IDLE: if (start_i) begin
        mask_d  = ch_mask_i;
        cont_d  = cont_i;
        trst_d  = t_rst_i;
        tsh_d   = t_sh_i;
        tcmp_d  = t_cmp_i;
        acc_d   = '0;
        ch_d    = '0;
        cnt_d   = len_m1(t_rst_i);
        state_d = ch_mask_i[0] ? S_RST : S_NEXT;
      end
      S_RST: if (cnt_q == '0) begin
        state_d = S_SAMPLE;
        cnt_d   = len_m1(tsh_q);
      end else cnt_d = cnt_q - CNT_W'(1);
      S_SAMPLE: if (cnt_q == '0) begin
        state_d = S_COMPARE;
        cnt_d   = len_m1(tcmp_q);
      end else cnt_d = cnt_q - CNT_W'(1);
      S_COMPARE: if (cnt_q == '0) state_d = S_LATCH;
                 else cnt_d = cnt_q - CNT_W'(1);
      S_LATCH: begin
        acc_d   = acc_q | ({N_PIX{cmp_s2_q}} & cur_oh);
        state_d = S_NEXT;
      end
      S_NEXT: if (ch_q == LAST_CH) begin
        code_d  = acc_q;
        state_d = S_DONE;
      end else begin
        ch_d    = ch_inc;
        cnt_d   = len_m1(trst_q);
        state_d = (|(mask_q & nxt_oh)) ? S_RST : S_NEXT;
      end
      S_DONE: if (valid_q && code_if.code_ready_i) begin
        if (cont_q) begin
          acc_d   = '0;
          ch_d    = '0;
          cnt_d   = len_m1(trst_q);
          state_d = mask_q[0] ? S_RST : S_NEXT;
        end else state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort wins over everything but reset; the delivered code survives it.
    if (abort_i) begin
      state_d = S_IDLE;
      code_d  = code_q;
    end

    d_oh     = N_PIX'(1) << ch_d;
    sh_rst_d = (state_d == S_RST);
    sh_d     = (state_d == S_SAMPLE);
    sh_cmp_d = (state_d == S_COMPARE);
    sw1_d    = sh_rst_d | sh_d;
    sw2_d    = sh_cmp_d;
    pd_a_d   = sw1_d ? d_oh : '0;
    pd_b_d   = sw2_d ? d_oh : '0;
    busy_d   = (state_d != S_IDLE);
    // Valid trails DONE entry by one cycle so code_o is settled before it is offered.
    valid_d  = (state_d == S_DONE) && (state_q == S_DONE);
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      state_q  <= S_IDLE;
      ch_q     <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      code_q   <= '0;
      mask_q   <= '0;
      cont_q   <= 1'b0;
      trst_q   <= '0;
      tsh_q    <= '0;
      tcmp_q   <= '0;
      cmp_s1_q <= 1'b0;
      cmp_s2_q <= 1'b0;
      sw1_q    <= 1'b0;
      sw2_q    <= 1'b0;
      sh_rst_q <= 1'b0;
      sh_q     <= 1'b0;
      sh_cmp_q <= 1'b0;
      pd_a_q   <= '0;
      pd_b_q   <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      code_q   <= code_d;
      mask_q   <= mask_d;
      cont_q   <= cont_d;
      trst_q   <= trst_d;
      tsh_q    <= tsh_d;
      tcmp_q   <= tcmp_d;
      cmp_s1_q <= cmp_i;
      cmp_s2_q <= cmp_s1_q;
      sw1_q    <= sw1_d;
      sw2_q    <= sw2_d;
      sh_rst_q <= sh_rst_d;
      sh_q     <= sh_d;
      sh_cmp_q <= sh_cmp_d;
      pd_a_q   <= pd_a_d;
      pd_b_q   <= pd_b_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
    end
  end

  assign sw1_o                = sw1_q;
  assign sw2_o                = sw2_q;
  assign sh_rst_o             = sh_rst_q;
  assign sh_o                 = sh_q;
  assign sh_cmp_o             = sh_cmp_q;
  assign pd_a_o               = pd_a_q;
  assign pd_b_o               = pd_b_q;
  assign busy_o               = busy_q;
  assign code_if.code_o       = code_q;
  assign code_if.code_valid_o = valid_q;

endmodule
